seq_mult_responder: RTL and testbench

- Iterative 256x256 -> 512-bit unsigned multiplier.
- Responder side of the start/done multiply handshake used by the modular-reduction controller; drop-in alternative to the Karatsuba unit.
- Trades latency for area: one DIGIT_W-bit slice of B per clock, shift-add accumulation.
- Operands are latched at start, so the initiator may change its X/fold and modulus muxes immediately after issuing start.

---
 rtl/seq_mult_responder.sv | 93 +++++++++
 tb/tb_seq_mult_responder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_mult_responder.sv
// Iterative 256x256 -> 512-bit unsigned multiplier (start/done responder), one DIGIT_W slice of B per clock.
// Optional: define SEQMUL_ZERO_SKIP_EN to short-cut zero operands to a 2-clock latency.
module seq_mult_responder #(
  parameter int DIGIT_W = 32
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [255:0] A,
  input  logic [255:0] B,
  input  logic         start,
  output logic [511:0] P,
  output logic         done
);

  localparam int NDIG  = 256 / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (!(DIGIT_W == 8 || DIGIT_W == 16 || DIGIT_W == 32 || DIGIT_W == 64)) begin : g_bad_digit_w
      $error("seq_mult_responder: DIGIT_W must be 8, 16, 32 or 64");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t                 state, state_nx;
  logic [255:0]           a_r, b_r;
  logic [511:0]           acc;
  logic [CNT_W-1:0]       cnt;
  logic [256+DIGIT_W-1:0] pp;
  logic [511:0]           pp_sh;
  logic                   last;
  logic                   zero_op;

  always_comb begin
    pp    = {{DIGIT_W{1'b0}}, a_r} * {256'd0, b_r[DIGIT_W-1:0]};
    pp_sh = {{(256 - DIGIT_W){1'b0}}, pp} << (cnt * DIGIT_W);
    last  = (cnt == CNT_W'(NDIG - 1));
`ifdef SEQMUL_ZERO_SKIP_EN
    zero_op = (A == '0) || (B == '0);
`else
    zero_op = 1'b0;
`endif
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
      P     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            // Zero operands enter RUN at its final step with a zero multiplier,
            // so the result is 0 and done lands two edges after start.
            a_r <= A;
            b_r <= zero_op ? '0 : B;
            acc <= '0;
            cnt <= zero_op ? CNT_W'(NDIG - 1) : '0;
          end
        end
        RUN: begin
          acc <= acc + pp_sh;
          b_r <= b_r >> DIGIT_W;
          cnt <= cnt + 1'b1;
        end
        FINISH: begin
          P    <= acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_responder.sv
// Scoreboard bench for seq_mult_responder (DIGIT_W=32): directed vectors, decoupled done monitor.
module tb_seq_mult_responder;

  logic         clock = 1'b0;
  logic         rst   = 1'b1;
  logic [255:0] A     = '1;
  logic [255:0] B     = '1;
  logic         start = 1'b1;
  logic [511:0] P;
  logic         done;

  seq_mult_responder #(.DIGIT_W(32)) dut (
    .clock(clock), .rst(rst), .A(A), .B(B), .start(start), .P(P), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [511:0] p;
    int unsigned  c;
  } exp_t;

  exp_t         sb[$];
  int unsigned  cyc = 0;
  int unsigned  n_cmp = 0;
  int unsigned  n_mis = 0;
  logic         rst_seen = 1'b1;
  logic [511:0] p_hold = '0;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // Monitor: every done must match the oldest expectation in value and cycle.
  always @(negedge clock) begin
    exp_t e;
    if (rst_seen) begin
      n_cmp++;
      if (P !== '0 || done !== 1'b0) begin
        n_mis++;
        $display("FAIL reset: P=%h done=%b, required P=0 done=0", P, done);
      end
      p_hold = '0;
    end else if (done === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
        p_hold = P;
      end else begin
        e = sb.pop_front();
        if (P !== e.p) begin
          n_mis++;
          $display("FAIL product: P=%h, required %h", P, e.p);
        end
        n_cmp++;
        if (cyc != e.c) begin
          n_mis++;
          $display("FAIL latency: done at cycle %0d, required cycle %0d", cyc, e.c);
        end
        p_hold = e.p;
      end
    end else begin
      n_cmp++;
      if (P !== p_hold || done !== 1'b0) begin
        n_mis++;
        $display("FAIL hold: P=%h done=%b, required P=%h done=0", P, done, p_hold);
      end
      if (sb.size() > 0 && cyc > sb[0].c) begin
        n_cmp++;
        n_mis++;
        $display("FAIL missing_done: no done by cycle %0d, required at cycle %0d", cyc, sb[0].c);
        void'(sb.pop_front());
      end
    end
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Start accepted at the next posedge; done is seen at the negedge 10 edges on.
  task automatic issue(input logic [255:0] a, input logic [255:0] b, input logic [511:0] p);
    @(negedge clock);
    A = a; B = b; start = 1'b1;
    sb.push_back('{p: p, c: cyc + 10});
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [511:0] exp_max;
    exp_max = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};

    // Reset held with start asserted, then idle with no done expected.
    repeat (3) @(negedge clock);
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clock);

    issue('1, '1, exp_max);
    drain();

    // Operands change and start pulses arrive while the request is running.
    @(negedge clock);
    A = 256'd3; B = 256'd5; start = 1'b1;
    sb.push_back('{p: 512'd15, c: cyc + 10});
    for (int i = 1; i <= 9; i++) begin
      @(negedge clock);
      A = rnd256(); B = rnd256();
      start = (i == 2 || i == 5 || i == 9);
    end
    @(negedge clock);
    start = 1'b0;
    drain();

    // Back-to-back: next start issued in the done cycle.
    issue(256'd1 << 255, 256'd2, 512'd1 << 256);
    for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clock);
    A = 256'd7; B = 256'd11; start = 1'b1;
    sb.push_back('{p: 512'd77, c: cyc + 10});
    @(negedge clock);
    start = 1'b0;
    drain();

    // Reset in the 4th RUN clock aborts the request.
    @(negedge clock);
    A = 256'd12345; B = 256'd12345; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    repeat (15) @(negedge clock);
    issue(256'd6, 256'd7, 512'd42);
    drain();

    issue(256'd1 << 200, 256'd1 << 100, 512'd1 << 300);
    drain();
    issue('1, 256'd1, {256'd0, {256{1'b1}}});
    drain();
    issue(256'd0, '1, 512'd0);
    drain();
    issue(256'h1_0000_0000, 256'hFFFF_FFFF, 512'hFFFF_FFFF_0000_0000);
    drain();
    repeat (5) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete by 100000 time units");
    $fatal(1);
  end

endmodule
